// File: rtl/alu_seq.sv
// Handshaked sequential ALU: single-cycle logic/arith/shift ops, optional shift-add multiplier.
// Define ALU_SEQ_MPY_EN to build the multiplier; otherwise MPY is reported as an illegal opcode.
module alu_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       opcode,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_out,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v,
    output logic             flag_err
);

    localparam logic [4:0] OP_ADD = 5'd0;
    localparam logic [4:0] OP_SUB = 5'd1;
    localparam logic [4:0] OP_AND = 5'd3;
    localparam logic [4:0] OP_OR  = 5'd4;
    localparam logic [4:0] OP_XOR = 5'd5;
    localparam logic [4:0] OP_SHL = 5'd6;
    localparam logic [4:0] OP_SRL = 5'd7;
    localparam logic [4:0] OP_SRA = 5'd8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             accept;
    logic             mpy_sel;
    logic [SHW-1:0]   shamt;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;
    logic             alu_err;
    logic             res_load;
    logic [WIDTH-1:0] res_next;
    logic             c_next;
    logic             v_next;
    logic             err_next;

    assign accept = in_valid && in_ready;
    assign shamt  = data_b[SHW-1:0];

`ifdef ALU_SEQ_MPY_EN
    localparam logic [4:0]  OP_MPY = 5'd2;
    localparam int unsigned W2     = 2 * WIDTH;
    localparam int unsigned CW     = $clog2(WIDTH);

    logic [W2-1:0]    mul_acc;
    logic [W2-1:0]    mul_cand;
    logic [WIDTH-1:0] mul_plier;
    logic [CW-1:0]    mul_cnt;
    logic [W2-1:0]    mul_step;
    logic             mul_last;

    assign mpy_sel  = (opcode == OP_MPY);
    assign mul_step = mul_acc + (mul_plier[0] ? mul_cand : W2'(0));
    assign mul_last = (mul_cnt == CW'(WIDTH - 1));

    // One radix-2 shift-add step per BUSY cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_acc   <= '0;
            mul_cand  <= '0;
            mul_plier <= '0;
            mul_cnt   <= '0;
        end else if (accept && mpy_sel) begin
            mul_acc   <= '0;
            mul_cand  <= W2'(data_a);
            mul_plier <= data_b;
            mul_cnt   <= '0;
        end else if (state == BUSY) begin
            mul_acc   <= mul_step;
            mul_cand  <= mul_cand << 1;
            mul_plier <= mul_plier >> 1;
            mul_cnt   <= mul_cnt + CW'(1);
        end
    end
`else
    assign mpy_sel = 1'b0;
`endif

    // Single-cycle operations evaluated straight from the request inputs
    always_comb begin
        sum     = {1'b0, data_a} + {1'b0, data_b};
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_err = 1'b0;
        case (opcode)
            OP_ADD: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (data_a[WIDTH-1] == data_b[WIDTH-1]) &&
                          (alu_res[WIDTH-1] != data_a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = data_a - data_b;
                alu_c   = (data_a < data_b);
                alu_v   = (data_a[WIDTH-1] != data_b[WIDTH-1]) &&
                          (alu_res[WIDTH-1] != data_a[WIDTH-1]);
            end
            OP_AND:  alu_res = data_a & data_b;
            OP_OR:   alu_res = data_a | data_b;
            OP_XOR:  alu_res = data_a ^ data_b;
            OP_SHL:  alu_res = data_a << shamt;
            OP_SRL:  alu_res = data_a >> shamt;
            OP_SRA:  alu_res = WIDTH'($signed(data_a) >>> shamt);
            default: alu_err = 1'b1;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = mpy_sel ? BUSY : DONE;
                end
            end
            BUSY: begin
`ifdef ALU_SEQ_MPY_EN
                if (mul_last) begin
                    state_next = DONE;
                end
`else
                state_next = IDLE;
`endif
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Result selection: single-cycle result on accept, product at the end of BUSY
    always_comb begin
        res_load = accept && !mpy_sel;
        res_next = alu_res;
        c_next   = alu_c;
        v_next   = alu_v;
        err_next = alu_err;
`ifdef ALU_SEQ_MPY_EN
        if (state == BUSY && mul_last) begin
            res_load = 1'b1;
            res_next = mul_step[WIDTH-1:0];
            c_next   = |mul_step[W2-1:WIDTH];
            v_next   = 1'b0;
            err_next = 1'b0;
        end
`endif
    end

    // Registered handshake and result outputs; result held until the next load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            data_out  <= '0;
            flag_z    <= 1'b0;
            flag_c    <= 1'b0;
            flag_v    <= 1'b0;
            flag_err  <= 1'b0;
        end else begin
            in_ready  <= (state_next == IDLE);
            out_valid <= (state_next == DONE);
            if (res_load) begin
                data_out <= res_next;
                flag_z   <= (res_next == '0);
                flag_c   <= c_next;
                flag_v   <= v_next;
                flag_err <= err_next;
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Randomized self-checking bench for alu_seq (WIDTH=32) against an arithmetic reference model.
module tb_alu_seq;

    localparam bit [4:0] OP_ADD = 5'd0;
    localparam bit [4:0] OP_SUB = 5'd1;
    localparam bit [4:0] OP_MPY = 5'd2;
    localparam bit [4:0] OP_AND = 5'd3;
    localparam bit [4:0] OP_OR  = 5'd4;
    localparam bit [4:0] OP_XOR = 5'd5;
    localparam bit [4:0] OP_SHL = 5'd6;
    localparam bit [4:0] OP_SRL = 5'd7;
    localparam bit [4:0] OP_SRA = 5'd8;
    localparam longint SMAX = 64'sh7FFF_FFFF;
    localparam longint SMIN = -64'sh8000_0000;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  opcode;
    logic [31:0] data_a;
    logic [31:0] data_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] data_out;
    logic        flag_z;
    logic        flag_c;
    logic        flag_v;
    logic        flag_err;

    int n_checks = 0;
    int n_errors = 0;

    alu_seq #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .data_a    (data_a),
        .data_b    (data_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .flag_z    (flag_z),
        .flag_c    (flag_c),
        .flag_v    (flag_v),
        .flag_err  (flag_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference behaviour from the arithmetic definition of each operation
    task automatic model(input bit [4:0] op, input bit [31:0] a, input bit [31:0] b,
                         output bit [31:0] r, output bit [3:0] flags, output int lat);
        longint unsigned ua, ub, full;
        longint sa, sb, s;
        int sh;
        bit c, v, err;
        ua = a; ub = b;
        sa = $signed(a); sb = $signed(b);
        sh = int'(b[4:0]);
        r = 0; c = 0; v = 0; err = 0; lat = 1;
        case (op)
            OP_ADD: begin
                full = ua + ub; r = full[31:0]; c = (full >> 32) != 0;
                s = sa + sb; v = (s > SMAX) || (s < SMIN);
            end
            OP_SUB: begin
                r = a - b; c = ua < ub;
                s = sa - sb; v = (s > SMAX) || (s < SMIN);
            end
`ifdef ALU_SEQ_MPY_EN
            OP_MPY: begin
                full = ua * ub; r = full[31:0]; c = (full >> 32) != 0; lat = 33;
            end
`endif
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_XOR: r = a ^ b;
            OP_SHL: r = a << sh;
            OP_SRL: r = a >> sh;
            OP_SRA: r = a[31] ? ~((~a) >> sh) : (a >> sh);
            default: err = 1;
        endcase
        flags = {(r == 0), c, v, err};
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("ready_before_req", in_ready, 1);
    endtask

    task automatic run_op(input bit [4:0] op, input bit [31:0] a, input bit [31:0] b, input int hold);
        bit [31:0] er;
        bit [3:0]  ef;
        int        elat;
        int        lat;
        bit        ready_seen;
        logic [31:0] held_d;
        logic [3:0]  held_f;
        model(op, a, b, er, ef, elat);
        wait_ready();
        in_valid = 1; opcode = op; data_a = a; data_b = b;
        @(negedge clk);
        in_valid = 0; opcode = 5'($urandom); data_a = $urandom; data_b = $urandom;
        lat = 1;
        ready_seen = 0;
        while (!out_valid && lat < 100) begin
            ready_seen |= in_ready;
            @(negedge clk);
            lat++;
        end
        check($sformatf("latency op%0d", op), 64'(lat), 64'(elat));
        check($sformatf("ready_while_busy op%0d", op), ready_seen, 0);
        check($sformatf("data op%0d a=%0h b=%0h", op, a, b), data_out, er);
        check($sformatf("flags zcve op%0d a=%0h b=%0h", op, a, b), {flag_z, flag_c, flag_v, flag_err}, ef);
        check($sformatf("ready_in_done op%0d", op), in_ready, 0);
        held_d = data_out;
        held_f = {flag_z, flag_c, flag_v, flag_err};
        repeat (hold) begin
            in_valid = 1; opcode = 5'($urandom); data_a = $urandom; data_b = $urandom;
            @(negedge clk);
            check("hold_stable", {out_valid, in_ready, data_out, flag_z, flag_c, flag_v, flag_err},
                  {1'b1, 1'b0, held_d, held_f});
        end
        in_valid = 0;
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;
        check("handoff valid/ready", {out_valid, in_ready}, 2'b01);
    endtask

    // Abort an operation with reset a given number of cycles after accept
    task automatic reset_mid(input bit [4:0] op, input int after);
        bit seen_valid;
        wait_ready();
        in_valid = 1; opcode = op; data_a = 32'd8; data_b = 32'd7;
        @(negedge clk);
        in_valid = 0;
        repeat (after) @(negedge clk);
        rst_n = 0;
        #1;
        check("reset_outputs", {in_ready, out_valid, data_out, flag_z, flag_c, flag_v, flag_err}, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        #1;
        check("ready_low_at_release", in_ready, 0);
        @(negedge clk);
        check("ready_after_release", in_ready, 1);
        seen_valid = 0;
        repeat (40) begin
            seen_valid |= out_valid;
            @(negedge clk);
        end
        check("no_result_after_abort", seen_valid, 0);
    endtask

    function automatic bit [31:0] rnd_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst_n = 0; in_valid = 0; out_ready = 0;
        opcode = '0; data_a = '0; data_b = '0;
        #1;
        check("reset_state", {in_ready, out_valid, data_out, flag_z, flag_c, flag_v, flag_err}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1;
        #1;
        check("initial_ready_low", in_ready, 0);
        @(negedge clk);
        check("initial_ready_high", in_ready, 1);

        run_op(OP_ADD, 32'd1, 32'd5, 0);
        run_op(OP_ADD, -32'sd5, 32'd8, 1);
        run_op(OP_SUB, 32'd0, 32'd3, 0);
        run_op(OP_ADD, 32'h7FFF_FFFF, 32'd1, 0);
        run_op(OP_SUB, 32'h8000_0000, 32'd1, 0);
        run_op(OP_MPY, 32'd8, 32'd7, 0);
        run_op(OP_MPY, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2);
        run_op(OP_SRA, -32'sd200, 32'd255, 0);
        run_op(OP_SRL, -32'sd200, 32'd4, 0);
        run_op(OP_SHL, -32'sd4, 32'd2, 0);
        run_op(OP_AND, 32'hF0F0_1234, 32'h0F0F_4321, 0);
        run_op(OP_OR,  32'hF0F0_0000, 32'h0F0F_0000, 0);
        run_op(OP_XOR, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 0);
        run_op(5'd9, 32'd1, 32'd2, 0);
        run_op(5'd31, 32'hFFFF_FFFF, 32'd2, 0);
        run_op(OP_ADD, 32'd100, 32'd23, 5);

        reset_mid(OP_MPY, 9);
        run_op(OP_ADD, 32'd1, 32'd5, 0);
        reset_mid(OP_ADD, 0);
        run_op(OP_SUB, 32'd10, 32'd3, 0);

        for (int i = 0; i < 300; i++) begin
            bit [4:0] op;
            op = (i % 50 == 49) ? 5'($urandom_range(16, 31)) : 5'($urandom_range(0, 11));
            run_op(op, rnd_operand(), rnd_operand(), $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits; legal values 8, 16, 32, 64.
REQ-002 Parameter SHW, default $clog2(WIDTH), number of data_b bits used as shift amount.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  operation request present.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 opcode  input  5  operation select; encodings ADD, SUB, MPY, AND, OR, XOR, SHL, SRL, SRA from defines.vh.
REQ-008 data_a, data_b  input  WIDTH each  operands.
REQ-009 out_valid  output  1  result present.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 data_out  output  WIDTH  result.
REQ-012 flag_z, flag_c, flag_v, flag_err  output  1 each  zero, carry/borrow, signed overflow, illegal opcode.

Function
REQ-013 FSM states IDLE, BUSY, DONE; in_ready SHALL be 1 only in IDLE.
REQ-014 Accept = in_valid && in_ready; opcode and operands SHALL be captured on accept; inputs ignored otherwise.
REQ-015 Non-MPY ops: IDLE->DONE on accept; result registered; out_valid high the following cycle (latency 1).
REQ-016 MPY: IDLE->BUSY on accept; radix-2 shift-add for exactly WIDTH cycles; BUSY->DONE; out_valid latency WIDTH+1.
REQ-017 DONE: out_valid=1, data_out and flags held stable until out_ready=1; DONE->IDLE on that edge.
REQ-018 in_ready stays 0 in DONE, so a new accept and a result handoff never occur in the same cycle.
REQ-019 ADD/SUB modulo 2^WIDTH; flag_c = carry-out (ADD) or unsigned borrow a<b (SUB); flag_v = signed overflow.
REQ-020 MPY returns low WIDTH bits of unsigned product; flag_c=1 iff upper WIDTH bits nonzero; flag_v=0.
REQ-021 AND/OR/XOR bitwise; flag_c=flag_v=0.
REQ-022 SHL/SRL logical, SRA arithmetic; shift amount = data_b[SHW-1:0], upper bits ignored; flag_c=flag_v=0.
REQ-023 flag_z = (data_out == 0) for every op.
REQ-024 Illegal opcode: data_out=0, flag_err=1, flag_z=1, other flags 0, latency 1; flag_err=0 for legal ops.

Reset
REQ-025 rst_n low SHALL immediately force IDLE, in_ready=0 while low, out_valid=0, data_out=0, all flags 0.
REQ-026 Reset during BUSY or DONE SHALL abort the operation; no result is emitted after release.
REQ-027 in_ready SHALL rise on the first clock edge after rst_n deasserts.

Configuration
REQ-028 Macro ALU_SEQ_MPY_EN defined: MPY implemented per REQ-016/020.
REQ-029 ALU_SEQ_MPY_EN undefined: no multiplier datapath, BUSY never entered; MPY handled as illegal opcode per REQ-024.

Verification
REQ-030 WIDTH=32, ADD a=1 b=5 -> out_valid 1 cycle after accept, data_out=6, all flags 0; a=-5 b=8 -> 3, flag_c=1.
REQ-031 SUB a=0 b=3 -> 0xFFFFFFFD, flag_c=1; ADD a=0x7FFFFFFF b=1 -> 0x80000000, flag_v=1.
REQ-032 MPY a=8 b=7 with macro -> 56 after 33 cycles, in_ready=0 meanwhile; without macro -> 0, flag_err=1 after 1 cycle.
REQ-033 SRA a=-200 b=255 -> 0xFFFFFFFF; SRL a=-200 b=4 -> 0x0FFFFFF3; SHL a=-4 b=2 -> 0xFFFFFFF0.
REQ-034 Hold out_ready=0 for 5 cycles after a result -> data_out/flags unchanged, in_ready=0, new in_valid ignored.
REQ-035 Assert rst_n low at cycle 10 of an MPY -> out_valid stays 0, in_ready=1 one edge after release, next ADD correct.
